// File: rtl/spi_sram_slave.sv
// spi_sram_slave: mode-0 SPI serial-SRAM slave with byte/page/sequential
// access, backed by an internal byte array of 2**ADDR_WIDTH entries.
// The 16-bit frame address is truncated to ADDR_WIDTH bits (9..16 supported).
//
// state   | meaning
// --------+-----------------------------------------------------------
// CMD     | collecting the 8-bit command
// ADDR_HI | collecting address bits [15:8]
// ADDR_LO | collecting address bits [7:0]
// WR_DATA | writing each completed byte to the array
// RD_DATA | shifting array bytes out on so
// SR_RD   | shifting the status byte out, repeated every 8 clocks
// SR_WR   | collecting the new status byte
// IGNORE  | discarding everything until csb rises
module spi_sram_slave #(
  parameter int ADDR_WIDTH = 13,
  parameter int PAGE_SIZE  = 32
) (
  input  logic sck,
  input  logic rst,
  input  logic csb,
  input  logic si,
  output logic so,
  output logic so_oe
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int HI_W  = ADDR_WIDTH - 8;
  localparam logic [ADDR_WIDTH-1:0] PMASK = ADDR_WIDTH'(PAGE_SIZE - 1);

  typedef enum logic [2:0] {
    CMD, ADDR_HI, ADDR_LO, WR_DATA, RD_DATA, SR_RD, SR_WR, IGNORE
  } state_t;

  state_t                  state;
  logic [2:0]              bitcnt;
  logic [7:0]              shreg;
  logic [HI_W-1:0]         addr_hi;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    is_read;
  logic [1:0]              mode;
  logic [7:0]              out_sr;
  logic                    tx_en;
  logic [7:0]              mem [0:DEPTH-1];

  logic [7:0]              byte_in;
  logic                    byte_done;
  logic                    byte_mode;
  logic [ADDR_WIDTH-1:0]   addr_new;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [7:0]              rd_data;
  logic                    wr_en;

  // Page mode wraps only the in-page bits; sequential wraps the whole array.
  function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [1:0] m);
    logic [ADDR_WIDTH-1:0] inc;
    inc = a + ADDR_WIDTH'(1);
    case (m)
      2'b01:   return inc;
      2'b10:   return (a & ~PMASK) | (inc & PMASK);
      default: return a;
    endcase
  endfunction

  assign byte_in   = {shreg[6:0], si};
  assign byte_done = (bitcnt == 3'd7);
  assign byte_mode = !((mode == 2'b10) || (mode == 2'b01));
  assign addr_new  = {addr_hi, byte_in};
  assign rd_addr   = (state == ADDR_LO) ? addr_new : addr;
  assign rd_data   = mem[rd_addr];
  assign wr_en     = !rst && !csb && (state == WR_DATA) && byte_done;

  // Frame sequencing, address tracking, status register and tx shift register.
  always_ff @(posedge sck) begin
    if (rst) begin
      state   <= CMD;
      bitcnt  <= 3'd0;
      shreg   <= 8'h00;
      addr_hi <= '0;
      addr    <= '0;
      is_read <= 1'b0;
      mode    <= 2'b00;
      out_sr  <= 8'h00;
      tx_en   <= 1'b0;
    end else if (csb) begin
      state  <= CMD;
      bitcnt <= 3'd0;
      shreg  <= 8'h00;
      out_sr <= 8'h00;
      tx_en  <= 1'b0;
    end else begin
      bitcnt <= bitcnt + 3'd1;
      shreg  <= byte_in;
      if (tx_en) out_sr <= {out_sr[6:0], 1'b0};
      if (byte_done) begin
        case (state)
          CMD: begin
            case (byte_in)
              8'h02: begin is_read <= 1'b0; state <= ADDR_HI; end
              8'h03: begin is_read <= 1'b1; state <= ADDR_HI; end
              8'h05: begin
                out_sr <= {mode, 6'b0};
                tx_en  <= 1'b1;
                state  <= SR_RD;
              end
              8'h01:   state <= SR_WR;
              default: state <= IGNORE;
            endcase
          end
          ADDR_HI: begin
            addr_hi <= byte_in[HI_W-1:0];
            state   <= ADDR_LO;
          end
          ADDR_LO: begin
            if (is_read) begin
              out_sr <= rd_data;
              tx_en  <= 1'b1;
              addr   <= advance(addr_new, mode);
              state  <= RD_DATA;
            end else begin
              addr  <= addr_new;
              state <= WR_DATA;
            end
          end
          WR_DATA: begin
            if (byte_mode) state <= IGNORE;
            else           addr  <= advance(addr, mode);
          end
          RD_DATA: begin
            if (byte_mode) begin
              tx_en <= 1'b0;
              state <= IGNORE;
            end else begin
              out_sr <= rd_data;
              addr   <= advance(addr, mode);
            end
          end
          SR_RD: out_sr <= {mode, 6'b0};
          SR_WR: begin
            mode  <= byte_in[7:6];
            state <= IGNORE;
          end
          default: state <= IGNORE;
        endcase
      end
    end
  end

  // Array write port: a byte lands only when its 8th bit is sampled.
  always_ff @(posedge sck) begin
    if (wr_en) mem[addr] <= byte_in;
  end

  // Output pad is launched on the falling edge so the master samples mid-bit.
  always_ff @(negedge sck) begin
    so    <= out_sr[7];
    so_oe <= tx_en;
  end

endmodule

// File: tb/tb_spi_sram_slave.sv
// tb_spi_sram_slave: directed frame vectors plus hand-written abort/reset
// sequences for spi_sram_slave.
module tb_spi_sram_slave;

  logic sck = 1'b0;
  logic rst = 1'b1;
  logic csb = 1'b1;
  logic si  = 1'b0;
  logic so;
  logic so_oe;

  int checks = 0;
  int errors = 0;

  spi_sram_slave #(.ADDR_WIDTH(13), .PAGE_SIZE(32)) dut (
    .sck  (sck),
    .rst  (rst),
    .csb  (csb),
    .si   (si),
    .so   (so),
    .so_oe(so_oe)
  );

  always #5 sck = ~sck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] addr;
    bit          has_addr;
    int          n;
    logic [31:0] tx;
    logic [31:0] exp_rx;
    logic [3:0]  chk_rx;
    logic [31:0] exp_oe;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive nb bits of v MSB first; capture so/so_oe as the master sees them.
  task automatic send_bits(input logic [7:0] v, input int nb,
                           output logic [7:0] r, output logic [7:0] o);
    r = 8'h00;
    o = 8'h00;
    for (int i = 0; i < nb; i++) begin
      @(negedge sck);
      #1;
      csb      = 1'b0;
      si       = v[7-i];
      r[7-i]   = so;
      o[7-i]   = so_oe;
    end
  endtask

  task automatic end_frame(output logic oe_after);
    @(negedge sck);
    #1;
    csb = 1'b1;
    si  = 1'b0;
    @(negedge sck);
    #1;
    oe_after = so_oe;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input bit has_addr,
                       input int n, input logic [31:0] tx,
                       output logic [31:0] rx, output logic [31:0] oe,
                       output logic hdr_oe, output logic end_oe);
    logic [7:0] r, o;
    rx = 32'h0;
    oe = 32'h0;
    send_bits(cmd, 8, r, o);
    hdr_oe = |o;
    if (has_addr) begin
      send_bits(addr[15:8], 8, r, o);
      hdr_oe = hdr_oe | (|o);
      send_bits(addr[7:0], 8, r, o);
      hdr_oe = hdr_oe | (|o);
    end
    for (int b = 0; b < n; b++) begin
      send_bits(tx[31-8*b -: 8], 8, r, o);
      rx[31-8*b -: 8] = r;
      oe[31-8*b -: 8] = o;
    end
    end_frame(end_oe);
  endtask

  initial begin
    logic [31:0] rx, oe;
    logic        hdr_oe, end_oe;
    logic [7:0]  r, o;

    //            cmd    addr      a  n  tx            exp_rx        chk      exp_oe
    vecs[0]  = '{8'h02, 16'h01AA, 1, 1, 32'hAD000000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[1]  = '{8'h03, 16'h01AA, 1, 2, 32'h00000000, 32'hAD000000, 4'b1000, 32'hFF000000};
    vecs[2]  = '{8'h01, 16'h0000, 0, 1, 32'h40000000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[3]  = '{8'h02, 16'h1FFF, 1, 3, 32'h11223300, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[4]  = '{8'h03, 16'h1FFF, 1, 3, 32'h00000000, 32'h11223300, 4'b1110, 32'hFFFFFF00};
    vecs[5]  = '{8'h03, 16'h0000, 1, 1, 32'h00000000, 32'h22000000, 4'b1000, 32'hFF000000};
    vecs[6]  = '{8'h05, 16'h0000, 0, 2, 32'h00000000, 32'h40400000, 4'b1100, 32'hFFFF0000};
    vecs[7]  = '{8'h02, 16'h0040, 1, 1, 32'h5A000000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[8]  = '{8'h01, 16'h0000, 0, 1, 32'h80000000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[9]  = '{8'h02, 16'h003F, 1, 2, 32'hA0A10000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[10] = '{8'h03, 16'h003F, 1, 2, 32'h00000000, 32'hA0A10000, 4'b1100, 32'hFFFF0000};
    vecs[11] = '{8'h03, 16'h0020, 1, 1, 32'h00000000, 32'hA1000000, 4'b1000, 32'hFF000000};
    vecs[12] = '{8'h03, 16'h0040, 1, 1, 32'h00000000, 32'h5A000000, 4'b1000, 32'hFF000000};
    vecs[13] = '{8'h07, 16'h0000, 0, 3, 32'hFFFFFF00, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[14] = '{8'h05, 16'h0000, 0, 1, 32'h00000000, 32'h80000000, 4'b1000, 32'hFF000000};
    vecs[15] = '{8'h03, 16'hFFFF, 1, 1, 32'h00000000, 32'h11000000, 4'b1000, 32'hFF000000};
    vecs[16] = '{8'h03, 16'h003F, 1, 1, 32'h00000000, 32'hA0000000, 4'b1000, 32'hFF000000};
    vecs[17] = '{8'h01, 16'h0000, 0, 1, 32'hFF000000, 32'h00000000, 4'b0000, 32'h00000000};
    vecs[18] = '{8'h05, 16'h0000, 0, 1, 32'h00000000, 32'hC0000000, 4'b1000, 32'hFF000000};
    vecs[19] = '{8'h03, 16'h0000, 1, 2, 32'h00000000, 32'h22000000, 4'b1000, 32'hFF000000};

    // Reset state
    repeat (3) @(negedge sck);
    #1;
    check("reset_so", {31'b0, so}, 32'h0);
    check("reset_so_oe", {31'b0, so_oe}, 32'h0);
    rst = 1'b0;
    frame(8'h05, 16'h0, 0, 1, 32'h0, rx, oe, hdr_oe, end_oe);
    check("reset_status", {24'h0, rx[31:24]}, 32'h0);

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      frame(vecs[i].cmd, vecs[i].addr, vecs[i].has_addr, vecs[i].n, vecs[i].tx,
            rx, oe, hdr_oe, end_oe);
      check($sformatf("v%0d_hdr_oe", i), {31'b0, hdr_oe}, 32'h0);
      check($sformatf("v%0d_oe", i), oe, vecs[i].exp_oe);
      check($sformatf("v%0d_end_oe", i), {31'b0, end_oe}, 32'h0);
      for (int b = 0; b < 4; b++)
        if (vecs[i].chk_rx[3-b])
          check($sformatf("v%0d_rx%0d", i, b), {24'h0, rx[31-8*b -: 8]},
                {24'h0, vecs[i].exp_rx[31-8*b -: 8]});
    end

    // Write abort after 5 data bits (status 0xC0: byte mode)
    frame(8'h02, 16'h0010, 1, 1, 32'h3C000000, rx, oe, hdr_oe, end_oe);
    send_bits(8'h02, 8, r, o);
    send_bits(8'h00, 8, r, o);
    send_bits(8'h10, 8, r, o);
    send_bits(8'hF8, 5, r, o);
    end_frame(end_oe);
    frame(8'h03, 16'h0010, 1, 1, 32'h0, rx, oe, hdr_oe, end_oe);
    check("abort_wr_hdr_oe", {31'b0, hdr_oe}, 32'h0);
    check("abort_wr_mem", {24'h0, rx[31:24]}, 32'h3C);

    // Read abort mid-byte: so_oe drops at the falling edge after csb rises
    send_bits(8'h03, 8, r, o);
    send_bits(8'h00, 8, r, o);
    send_bits(8'h10, 8, r, o);
    send_bits(8'h00, 4, r, o);
    check("abort_rd_oe", {24'h0, o}, 32'hF0);
    check("abort_rd_bits", {24'h0, r}, 32'h30);
    end_frame(end_oe);
    check("abort_rd_end_oe", {31'b0, end_oe}, 32'h0);

    // Reset mid-frame during a sequential write
    frame(8'h02, 16'h0102, 1, 1, 32'h99000000, rx, oe, hdr_oe, end_oe);
    frame(8'h01, 16'h0, 0, 1, 32'h40000000, rx, oe, hdr_oe, end_oe);
    send_bits(8'h02, 8, r, o);
    send_bits(8'h01, 8, r, o);
    send_bits(8'h00, 8, r, o);
    send_bits(8'h77, 8, r, o);
    send_bits(8'h88, 8, r, o);
    send_bits(8'hE0, 3, r, o);
    @(negedge sck);
    #1;
    rst = 1'b1;
    @(posedge sck);
    #1;
    rst = 1'b0;
    send_bits(8'h05, 8, r, o);
    check("rst_cmd_oe", {24'h0, o}, 32'h0);
    send_bits(8'h00, 8, r, o);
    check("rst_status", {24'h0, r}, 32'h00);
    check("rst_status_oe", {24'h0, o}, 32'hFF);
    end_frame(end_oe);
    frame(8'h03, 16'h0100, 1, 2, 32'h0, rx, oe, hdr_oe, end_oe);
    check("rst_mem100", {24'h0, rx[31:24]}, 32'h77);
    check("rst_byte_mode_oe", oe, 32'hFF000000);
    frame(8'h03, 16'h0101, 1, 1, 32'h0, rx, oe, hdr_oe, end_oe);
    check("rst_mem101", {24'h0, rx[31:24]}, 32'h88);
    frame(8'h03, 16'h0102, 1, 1, 32'h0, rx, oe, hdr_oe, end_oe);
    check("rst_mem102", {24'h0, rx[31:24]}, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
